// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 8-bit LFSR checker: polynomial taps, width, period,
// FSM state encoding and the next-value function used by generator and checker alike.
package lfsr_checker_pkg;

  localparam int LFSR_W      = 8;
  localparam int LFSR_PERIOD = 255;

  localparam int TAP_0 = 7;
  localparam int TAP_1 = 5;
  localparam int TAP_2 = 4;
  localparam int TAP_3 = 3;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Maximal-length Fibonacci step; 0x00 is the lock-up state and never appears in a valid stream.
  function automatic logic [LFSR_W-1:0] lfsr_next_f(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], x[TAP_0] ^ x[TAP_1] ^ x[TAP_2] ^ x[TAP_3]};
  endfunction

endpackage

// File: rtl/lfsr_checker_next.sv
// Combinational single-step LFSR advance, shared with the team LFSR generator.
module lfsr_next
  import lfsr_checker_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  assign nxt = lfsr_next_f(cur);

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR stream: acquires lock on LOCK_CNT
// consecutive predicted words, then flywheels, counting errors and sequence periods.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [LFSR_W-1:0] din,
  input  logic              din_valid,
  input  logic              clear_err,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic              period_done
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  state_e              state_r, state_nxt_s;
  logic [LFSR_W-1:0]   ref_r, ref_nxt_s;
  logic [LFSR_W-1:0]   anchor_r, anchor_nxt_s;
  logic [MATCH_W-1:0]  match_cnt_r, match_cnt_nxt_s;
  logic [MISS_W-1:0]   miss_cnt_r, miss_cnt_nxt_s;
  logic [LFSR_W-1:0]   pred_s;
  logic                accept_s;
  logic                mismatch_s;
  logic                din_zero_s;
  logic                err_hit_s;
  logic                wrap_s;

  logic                locked_r, locked_nxt_s;
  logic                err_pulse_r, err_pulse_nxt_s;
  logic [ERR_W-1:0]    err_count_r, err_count_nxt_s;
  logic                period_done_r, period_done_nxt_s;

  lfsr_next u_next (
    .cur (ref_r),
    .nxt (pred_s)
  );

  assign accept_s   = enable & din_valid;
  assign mismatch_s = (din != pred_s);
  assign din_zero_s = (din == {LFSR_W{1'b0}});

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_SEARCH;
      ref_r       <= {LFSR_W{1'b0}};
      anchor_r    <= {LFSR_W{1'b0}};
      match_cnt_r <= {MATCH_W{1'b0}};
      miss_cnt_r  <= {MISS_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      ref_r       <= ref_nxt_s;
      anchor_r    <= anchor_nxt_s;
      match_cnt_r <= match_cnt_nxt_s;
      miss_cnt_r  <= miss_cnt_nxt_s;
    end
  end

  // Next-state and datapath update on each accepted word
  always_comb begin
    state_nxt_s     = state_r;
    ref_nxt_s       = ref_r;
    anchor_nxt_s    = anchor_r;
    match_cnt_nxt_s = match_cnt_r;
    miss_cnt_nxt_s  = miss_cnt_r;
    err_hit_s       = 1'b0;
    wrap_s          = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_SEARCH: begin
          if (!din_zero_s) begin
            ref_nxt_s       = din;
            match_cnt_nxt_s = {MATCH_W{1'b0}};
            state_nxt_s     = ST_VERIFY;
          end else begin
            state_nxt_s = ST_SEARCH;
          end
        end
        ST_VERIFY: begin
          if (!mismatch_s) begin
            ref_nxt_s       = din;
            match_cnt_nxt_s = match_cnt_r + MATCH_W'(1);
            if (match_cnt_nxt_s == MATCH_W'(LOCK_CNT)) begin
              state_nxt_s    = ST_LOCKED;
              anchor_nxt_s   = din;
              miss_cnt_nxt_s = {MISS_W{1'b0}};
            end else begin
              state_nxt_s = ST_VERIFY;
            end
          end else if (!din_zero_s) begin
            ref_nxt_s       = din;
            match_cnt_nxt_s = {MATCH_W{1'b0}};
          end else begin
            match_cnt_nxt_s = {MATCH_W{1'b0}};
            state_nxt_s     = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the reference free-runs so a corrupted word cannot derail it.
          ref_nxt_s = pred_s;
          wrap_s    = (pred_s == anchor_r);
          if (mismatch_s) begin
            err_hit_s = 1'b1;
            if (miss_cnt_r + MISS_W'(1) == MISS_W'(LOSS_CNT)) begin
              miss_cnt_nxt_s = {MISS_W{1'b0}};
              state_nxt_s    = ST_SEARCH;
            end else begin
              miss_cnt_nxt_s = miss_cnt_r + MISS_W'(1);
            end
          end else begin
            miss_cnt_nxt_s = {MISS_W{1'b0}};
          end
        end
        default: begin
          state_nxt_s = ST_SEARCH;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output values to be registered alongside the state
  always_comb begin
    locked_nxt_s      = (state_nxt_s == ST_LOCKED);
    err_pulse_nxt_s   = err_hit_s;
    period_done_nxt_s = wrap_s;
    err_count_nxt_s   = err_count_r;
    if (clear_err) begin
      err_count_nxt_s = err_hit_s ? ERR_W'(1) : {ERR_W{1'b0}};
    end else if (err_hit_s && !(&err_count_r)) begin
      err_count_nxt_s = err_count_r + ERR_W'(1);
    end else begin
      err_count_nxt_s = err_count_r;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_r      <= 1'b0;
      err_pulse_r   <= 1'b0;
      err_count_r   <= {ERR_W{1'b0}};
      period_done_r <= 1'b0;
    end else begin
      locked_r      <= locked_nxt_s;
      err_pulse_r   <= err_pulse_nxt_s;
      err_count_r   <= err_count_nxt_s;
      period_done_r <= period_done_nxt_s;
    end
  end

  assign locked      = locked_r;
  assign err_pulse   = err_pulse_r;
  assign err_count   = err_count_r;
  assign period_done = period_done_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed self-checking bench for lfsr_checker: acquisition, error handling,
// loss/re-lock, period detection, enable gating, clear_err and async reset.
module tb_lfsr_checker;
  import lfsr_checker_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  din;
  logic        din_valid;
  logic        clear_err;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        period_done;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .din         (din),
    .din_valid   (din_valid),
    .clear_err   (clear_err),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .period_done (period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [7:0] w);
    din       = w;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  cur;
    logic [15:0] saved_err;
    int pd_cnt, pd_first, pd_second, err_seen;

    rst_n = 1'b0; enable = 1'b0; din = 8'h00; din_valid = 1'b0; clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_period_done", 32'(period_done), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;

    // Acquisition on the hand-computed stream D3 A6 4C 99 33
    send(8'hD3);
    send(8'hA6);
    send(8'h4C);
    send(8'h99);
    check("acq_not_yet", 32'(locked), 32'd0);
    send(8'h33);
    check("acq_locked", 32'(locked), 32'd1);
    check("acq_err_count", 32'(err_count), 32'd0);
    cur = 8'h33;

    // Single corrupted word
    cur = tb_next(cur);
    send(8'h00);
    check("corrupt_pulse", 32'(err_pulse), 32'd1);
    check("corrupt_count", 32'(err_count), 32'd1);
    check("corrupt_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cur = tb_next(cur);
      send(cur);
      check("post_corrupt_no_err", 32'({err_pulse, locked}), 32'b01);
    end
    check("post_corrupt_count", 32'(err_count), 32'd1);

    // Three consecutive wrong words drop lock
    for (int i = 0; i < 3; i++) begin
      cur = tb_next(cur);
      send(cur ^ 8'h01);
      check("loss_pulse", 32'(err_pulse), 32'd1);
      check("loss_locked", 32'(locked), (i < 2) ? 32'd1 : 32'd0);
    end
    check("loss_count", 32'(err_count), 32'd4);

    // Correct stream re-locks after LOCK_CNT+1 words
    for (int i = 0; i < 4; i++) begin
      cur = tb_next(cur);
      send(cur);
    end
    check("relock_not_yet", 32'(locked), 32'd0);
    cur = tb_next(cur);
    send(cur);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_count_kept", 32'(err_count), 32'd4);

    // Two full periods from the anchor
    pd_cnt = 0; pd_first = 0; pd_second = 0; err_seen = 0;
    for (int k = 1; k <= 2 * LFSR_PERIOD; k++) begin
      cur = tb_next(cur);
      send(cur);
      if (period_done) begin
        pd_cnt++;
        if (pd_cnt == 1) pd_first = k;
        else if (pd_cnt == 2) pd_second = k;
      end
      if (err_pulse) err_seen++;
    end
    check("period_count", 32'(pd_cnt), 32'd2);
    check("period_first", 32'(pd_first), 32'd255);
    check("period_second", 32'(pd_second), 32'd510);
    check("period_no_err", 32'(err_seen), 32'd0);

    // enable low: random valid words must be ignored
    saved_err = err_count;
    enable    = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check("disabled_hold", 32'({locked, err_pulse, period_done, err_count}),
            32'({1'b1, 1'b0, 1'b0, saved_err}));
    end
    din_valid = 1'b0;
    enable    = 1'b1;
    cur = tb_next(cur);
    send(cur);
    check("disabled_ref_held", 32'({err_pulse, locked}), 32'b01);

    // clear_err coinciding with an error
    cur = tb_next(cur);
    clear_err = 1'b1;
    send(cur ^ 8'h80);
    clear_err = 1'b0;
    check("clear_hit_count", 32'(err_count), 32'd1);
    check("clear_hit_pulse", 32'(err_pulse), 32'd1);
    cur = tb_next(cur);
    send(cur);
    check("clear_then_ok", 32'({err_count, err_pulse, locked}), 32'({16'd1, 1'b0, 1'b1}));
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
    check("clear_only", 32'(err_count), 32'd0);

    // Asynchronous reset mid-lock
    check("pre_reset_locked", 32'(locked), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_locked", 32'(locked), 32'd0);
    check("async_err_pulse", 32'(err_pulse), 32'd0);
    check("async_err_count", 32'(err_count), 32'd0);
    check("async_period_done", 32'(period_done), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
